// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use and multicycle-op stall detection with saturating stall counter
module hazard_ctrl #(
  parameter int AW = 4,
  parameter int MC_LAT = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          id_mc,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_memread,
  input  logic          ex_mc_start,
  input  logic [AW-1:0] exmem_rd,
  input  logic [AW-1:0] memwb_rd,
  input  logic          exmem_regwrite,
  input  logic          memwb_regwrite,
  output logic [1:0]    fa,
  output logic [1:0]    fb,
  output logic          stall,
  output logic          mc_busy,
  output logic          mc_err,
  output logic [CW-1:0] stall_cnt
);
  typedef enum logic {IDLE, MC_WAIT} state_t;
  state_t state, next_state;
  logic [AW-1:0] mc_rd, next_mc_rd;
  logic [7:0] mc_cnt, next_mc_cnt;
  logic lu, mh, ex_fwd_a, ex_fwd_b, wb_fwd_a, wb_fwd_b;
  always_comb begin
    ex_fwd_a = exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_rs;
    ex_fwd_b = exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_rt;
    wb_fwd_a = memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_rs;
    wb_fwd_b = memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_rt;
    fa = ex_fwd_a ? 2'b10 : wb_fwd_a ? 2'b01 : 2'b00;
    fb = ex_fwd_b ? 2'b10 : wb_fwd_b ? 2'b01 : 2'b00;
    lu = ex_memread && ex_rd != '0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    mh = mc_busy && (id_mc || (mc_rd != '0 && (mc_rd == id_rs || (id_uses_rt && mc_rd == id_rt))));
    stall = lu || mh;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mc_rd     <= '0;
      mc_cnt    <= '0;
      mc_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= next_state;
      mc_rd  <= next_mc_rd;
      mc_cnt <= next_mc_cnt;
      if (state == MC_WAIT && ex_mc_start) mc_err <= 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  // a start while busy is ignored here; only mc_err records it
  always_comb begin
    next_state  = state;
    next_mc_rd  = mc_rd;
    next_mc_cnt = mc_cnt;
    if (state == IDLE) begin
      if (ex_mc_start) begin
        next_state  = MC_WAIT;
        next_mc_rd  = ex_rd;
        next_mc_cnt = 8'(MC_LAT - 1);
      end
    end else begin
      next_state  = mc_cnt == 8'd0 ? IDLE : MC_WAIT;
      next_mc_cnt = mc_cnt == 8'd0 ? 8'd0 : mc_cnt - 8'd1;
    end
  end
  always_comb mc_busy = state == MC_WAIT;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, multicycle tracking, reset and saturation
module tb_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0, exmem_rd = '0, memwb_rd = '0;
  logic id_uses_rt = 0, id_mc = 0, ex_memread = 0, ex_mc_start = 0, exmem_regwrite = 0, memwb_regwrite = 0;
  logic [1:0] fa, fb, fa2, fb2;
  logic stall, mc_busy, mc_err, stall2, mc_busy2, mc_err2;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.AW(4), .MC_LAT(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mc(id_mc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .fa(fa), .fb(fb), .stall(stall), .mc_busy(mc_busy), .mc_err(mc_err), .stall_cnt(stall_cnt));
  hazard_ctrl #(.AW(4), .MC_LAT(4), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mc(id_mc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .fa(fa2), .fb(fb2), .stall(stall2), .mc_busy(mc_busy2), .mc_err(mc_err2), .stall_cnt(stall_cnt2));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_busy", 16'(mc_busy), 16'd0);
    chk("rst_err", 16'(mc_err), 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_fa", 16'(fa), 16'd0);
    #1 rst = 0;
    tick;
    exmem_regwrite = 1; exmem_rd = 5; memwb_regwrite = 1; memwb_rd = 5; ex_rs = 5; ex_rt = 5;
    #1;
    chk("fwd_both_fa", 16'(fa), 16'b10);
    chk("fwd_both_fb", 16'(fb), 16'b10);
    exmem_regwrite = 0;
    #1;
    chk("fwd_wb_fa", 16'(fa), 16'b01);
    chk("fwd_wb_fb", 16'(fb), 16'b01);
    exmem_regwrite = 1; exmem_rd = 0; ex_rt = 6;
    #1;
    chk("fwd_r0_fa", 16'(fa), 16'b01);
    chk("fwd_miss_fb", 16'(fb), 16'b00);
    exmem_rd = 6; memwb_rd = 0; ex_rs = 0; ex_rt = 6;
    #1;
    chk("fwd_r0_wb_fa", 16'(fa), 16'b00);
    chk("fwd_ex_fb", 16'(fb), 16'b10);
    exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; ex_rt = 0;
    ex_memread = 1; ex_rd = 3; id_rs = 3;
    #1;
    chk("lu_stall", 16'(stall), 16'd1);
    tick;
    chk("lu_cnt", stall_cnt, 16'd1);
    ex_rd = 0;
    #1;
    chk("lu_r0", 16'(stall), 16'd0);
    tick;
    chk("lu_cnt_hold", stall_cnt, 16'd1);
    ex_rd = 3; id_rs = 4; id_rt = 3; id_uses_rt = 0;
    #1;
    chk("lu_rt_unused", 16'(stall), 16'd0);
    id_uses_rt = 1;
    #1;
    chk("lu_rt_used", 16'(stall), 16'd1);
    ex_memread = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rd = 7; ex_mc_start = 1;
    #1;
    chk("mc_pre_busy", 16'(mc_busy), 16'd0);
    tick;
    ex_mc_start = 0; ex_rd = 0; id_rt = 7; id_uses_rt = 1;
    #1;
    chk("mc_busy1", 16'(mc_busy), 16'd1);
    chk("mc_stall1", 16'(stall), 16'd1);
    id_uses_rt = 0;
    #1;
    chk("mc_rt_unused", 16'(stall), 16'd0);
    id_mc = 1;
    #1;
    chk("mc_id_mc", 16'(stall), 16'd1);
    id_mc = 0; id_uses_rt = 1;
    tick;
    chk("mc_busy2", 16'(mc_busy), 16'd1);
    tick;
    chk("mc_busy3", 16'(mc_busy), 16'd1);
    tick;
    chk("mc_busy4", 16'(mc_busy), 16'd1);
    chk("mc_stall4", 16'(stall), 16'd1);
    tick;
    chk("mc_done", 16'(mc_busy), 16'd0);
    chk("mc_done_stall", 16'(stall), 16'd0);
    chk("mc_cnt", stall_cnt, 16'd5);
    id_rt = 0; id_uses_rt = 0;
    ex_rd = 9; ex_mc_start = 1;
    tick;
    ex_rd = 10;
    tick;
    ex_mc_start = 0; ex_rd = 0;
    #1;
    chk("err_set", 16'(mc_err), 16'd1);
    id_rs = 9;
    #1;
    chk("err_keep_rd", 16'(stall), 16'd1);
    id_rs = 10;
    #1;
    chk("err_no_reload", 16'(stall), 16'd0);
    id_rs = 0;
    tick;
    tick;
    chk("err_busy_last", 16'(mc_busy), 16'd1);
    tick;
    chk("err_window_end", 16'(mc_busy), 16'd0);
    chk("err_sticky", 16'(mc_err), 16'd1);
    chk("err_cnt", stall_cnt, 16'd5);
    ex_rd = 11; ex_mc_start = 1;
    tick;
    ex_mc_start = 0; ex_rd = 0; id_rs = 11;
    #1;
    chk("ar_pre_stall", 16'(stall), 16'd1);
    #1 rst = 1;
    exmem_regwrite = 1; exmem_rd = 5; ex_rs = 5;
    #1;
    chk("ar_busy", 16'(mc_busy), 16'd0);
    chk("ar_cnt", stall_cnt, 16'd0);
    chk("ar_err", 16'(mc_err), 16'd0);
    chk("ar_fa", 16'(fa), 16'b10);
    #1 rst = 0;
    exmem_regwrite = 0; exmem_rd = 0; ex_rs = 0;
    #1;
    chk("ar_no_stall", 16'(stall), 16'd0);
    tick;
    chk("ar_cnt_after", stall_cnt, 16'd0);
    ex_memread = 1; ex_rd = 3; id_rs = 3;
    tick; tick; tick;
    chk("sat_3", 16'(stall_cnt2), 16'd3);
    tick; tick;
    chk("sat_hold", 16'(stall_cnt2), 16'd3);
    chk("sat_wide", stall_cnt, 16'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 4, the register-address width.
REQ-002 The block SHALL have parameter MC_LAT, default 4, the multicycle-op result latency in cycles (legal range 1..255).
REQ-003 The block SHALL have parameter CW, default 16, the stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 id_rs, id_rt  in  AW  source registers of the instruction in ID.
REQ-007 id_uses_rt  in  1  ID instruction reads rt.
REQ-008 id_mc  in  1  ID instruction is a multicycle op.
REQ-009 ex_rs, ex_rt, ex_rd  in  AW  ID/EX source and destination registers.
REQ-010 ex_memread  in  1  ID/EX instruction is a load.
REQ-011 ex_mc_start  in  1  ID/EX instruction is a multicycle op entering the unit this cycle.
REQ-012 exmem_rd, memwb_rd  in  AW  destination registers in EX/MEM and MEM/WB.
REQ-013 exmem_regwrite, memwb_regwrite  in  1  write enables for those stages.
REQ-014 fa, fb  out  2  ALU operand-A/B mux select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-015 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-016 mc_busy  out  1  multicycle result pending.
REQ-017 mc_err  out  1  sticky; multicycle op issued while busy.
REQ-018 stall_cnt  out  CW  saturating count of stalled cycles.

Function
REQ-019 fa SHALL be combinational: 10 if exmem_regwrite and exmem_rd!=0 and exmem_rd==ex_rs; else 01 if memwb_regwrite and memwb_rd!=0 and memwb_rd==ex_rs; else 00.
REQ-020 fb SHALL follow REQ-019 using ex_rt; EX/MEM always has priority over MEM/WB when both match.
REQ-021 Register 0 SHALL never be forwarded, stalled on, or tracked.
REQ-022 The load-use hazard lu SHALL be combinational: ex_memread and ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
REQ-023 The FSM SHALL have two states: IDLE and MC_WAIT, and SHALL hold registers mc_rd (AW bits) and mc_cnt (8 bits).
REQ-024 In IDLE, ex_mc_start=1 at a rising edge SHALL capture mc_rd=ex_rd, load mc_cnt=MC_LAT-1, and move to MC_WAIT.
REQ-025 In MC_WAIT with mc_cnt!=0, each edge SHALL decrement mc_cnt; with mc_cnt==0, the next edge SHALL return to IDLE.
REQ-026 mc_busy SHALL equal (state==MC_WAIT); it is therefore high for exactly MC_LAT cycles after the start edge.
REQ-027 The multicycle hazard mh SHALL be combinational: mc_busy and (id_mc or (mc_rd!=0 and (mc_rd==id_rs or (id_uses_rt and mc_rd==id_rt)))).
REQ-028 stall SHALL be combinational and equal lu OR mh; simultaneous causes SHALL produce a single stall.
REQ-029 ex_mc_start=1 while in MC_WAIT SHALL be ignored by the FSM (no reload) and SHALL set mc_err=1 until reset.
REQ-030 stall_cnt SHALL increment by 1 on each edge where stall=1, and SHALL hold at all-ones when saturated.
REQ-031 fa, fb and stall SHALL have no dependence on FSM state other than through mc_busy and mc_rd.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, mc_rd=0, mc_cnt=0, mc_busy=0, mc_err=0 and stall_cnt=0, independent of clk.
REQ-033 A reset asserted during MC_WAIT SHALL abandon the pending op; after release, no stall SHALL be raised for the old mc_rd.
REQ-034 fa and fb SHALL remain purely input-driven during reset.

Verification
REQ-035 exmem_regwrite=1, exmem_rd=5, memwb_regwrite=1, memwb_rd=5, ex_rs=5, ex_rt=5 -> fa=10, fb=10; then exmem_regwrite=0 -> fa=01, fb=01.
REQ-036 ex_memread=1, ex_rd=3, id_rs=3 -> stall=1 and stall_cnt +1 after the edge; the same with ex_rd=0 -> stall=0.
REQ-037 MC_LAT=4, ex_mc_start=1, ex_rd=7 -> mc_busy high for 4 cycles; id_rt=7 with id_uses_rt=1 -> stall=1 for those cycles; id_uses_rt=0 -> stall=0.
REQ-038 Second ex_mc_start during MC_WAIT -> busy window unchanged and mc_err=1 until rst.
REQ-039 rst pulsed mid-MC_WAIT with no clk edge -> mc_busy=0, stall_cnt=0 immediately; with id_rs=mc_rd afterwards -> stall=0.
REQ-040 CW=2 with stall held for 5 cycles -> stall_cnt reaches 3 and holds.
